// File: rtl/contador_clk_multi.sv
// contador_clk_multi: timing-strobe generator running off the single system clock.
// It produces a divided pixel-rate enable strobe and a programmable ring/alarm
// square wave (continuous or burst) with a shadowed, runtime-reloadable half-period.
// Every output is a clock enable or a registered level; no derived clocks are made.
//
// Control semantics (level-sampled on each rising CLK_NX edge, no handshake):
//   ring_start is only honoured in IDLE and latches ring_mode/burst_len in the same
//   edge; ring_stop has priority over everything and aborts without ring_done;
//   half_period_ld writes the shadow register, which the ring counter picks up only
//   at start or at a half-period boundary, so a phase in progress is never cut short.
module contador_clk_multi #(
  parameter int PIX_DIV   = 4,
  parameter int RING_W    = 27,
  parameter int RING_HALF = 50000000,
  parameter int BURST_W   = 4,
  localparam int PW       = (PIX_DIV > 1) ? $clog2(PIX_DIV) : 1
) (
  input  logic               CLK_NX,
  input  logic               reset,
  input  logic               en_pix,
  input  logic               ring_start,
  input  logic               ring_stop,
  input  logic               ring_mode,
  input  logic [BURST_W-1:0] burst_len,
  input  logic               half_period_ld,
  input  logic [RING_W-1:0]  half_period,
  output logic               pixel_rate,
  output logic [PW-1:0]      pix_phase,
  output logic               clk_RING,
  output logic               ring_busy,
  output logic               ring_done
);

  // Ring FSM encoding; state_q is the single point a checker needs to observe.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HIGH = 2'd1,
    ST_LOW  = 2'd2
  } ring_state_e;

  localparam logic [PW-1:0]      PIX_LAST   = PW'(PIX_DIV - 1);
  localparam logic [RING_W-1:0]  RING_ONE   = RING_W'(1);
  localparam logic [RING_W-1:0]  RING_RST   = (RING_HALF == 0) ? RING_ONE : RING_W'(RING_HALF);
  localparam logic [BURST_W-1:0] BURST_ONE  = BURST_W'(1);

  // ---------------------------------------------------------------------------
  // Pixel divider
  // ---------------------------------------------------------------------------
  logic [PW-1:0] phase_q, phase_d;
  logic          rate_q, rate_d;

  // Count enabled cycles; strobe is registered from the wrap condition so the
  // first strobe lands PIX_DIV edges after en_pix goes high.
  always_comb begin
    phase_d = phase_q;
    rate_d  = 1'b0;
    if (en_pix) begin
      rate_d  = (phase_q == PIX_LAST);
      phase_d = (phase_q == PIX_LAST) ? '0 : phase_q + PW'(1);
    end else begin
      phase_d = '0;
    end
  end

  // Pixel divider registers.
  always_ff @(posedge CLK_NX or negedge reset) begin
    if (!reset) begin
      phase_q <= '0;
      rate_q  <= 1'b0;
    end else begin
      phase_q <= phase_d;
      rate_q  <= rate_d;
    end
  end

  assign pixel_rate = rate_q;
  assign pix_phase  = phase_q;

  // ---------------------------------------------------------------------------
  // Ring generator
  // ---------------------------------------------------------------------------
  ring_state_e        state_q, state_d;
  logic [RING_W-1:0]  cnt_q, cnt_d;
  logic [RING_W-1:0]  shadow_q, shadow_d;
  logic [BURST_W-1:0] rem_q, rem_d;
  logic               mode_q, mode_d;
  logic               clk_q, clk_d;
  logic               done_q, done_d;

  // Shadow half-period: a requested 0 is stored as 1 so a phase never has zero length.
  always_comb begin
    shadow_d = shadow_q;
    if (half_period_ld) begin
      shadow_d = (half_period == '0) ? RING_ONE : half_period;
    end
  end

  // Ring next-state logic. The counter holds the cycles left in the current
  // phase including the present one; a value of 1 marks the last cycle, so a
  // phase loaded with H lasts exactly H cycles. Boundary reloads read shadow_q,
  // so a load landing on the boundary edge only affects the following phase.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rem_d   = rem_q;
    mode_d  = mode_q;
    done_d  = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (ring_start && !ring_stop) begin
          state_d = ST_HIGH;
          cnt_d   = shadow_q;
          mode_d  = ring_mode;
          rem_d   = (burst_len == '0) ? BURST_ONE : burst_len;
        end
      end
      ST_HIGH: begin
        if (ring_stop) begin
          state_d = ST_IDLE;
        end else if (cnt_q == RING_ONE) begin
          state_d = ST_LOW;
          cnt_d   = shadow_q;
        end else begin
          cnt_d = cnt_q - RING_ONE;
        end
      end
      ST_LOW: begin
        if (ring_stop) begin
          state_d = ST_IDLE;
        end else if (cnt_q == RING_ONE) begin
          if (!mode_q) begin
            state_d = ST_HIGH;
            cnt_d   = shadow_q;
          end else if (rem_q > BURST_ONE) begin
            state_d = ST_HIGH;
            cnt_d   = shadow_q;
            rem_d   = rem_q - BURST_ONE;
          end else begin
            state_d = ST_IDLE;
            done_d  = 1'b1;
          end
        end else begin
          cnt_d = cnt_q - RING_ONE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    clk_d = (state_d == ST_HIGH);
  end

  // Ring state register and datapath registers.
  always_ff @(posedge CLK_NX or negedge reset) begin
    if (!reset) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      shadow_q <= RING_RST;
      rem_q    <= '0;
      mode_q   <= 1'b0;
      clk_q    <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      shadow_q <= shadow_d;
      rem_q    <= rem_d;
      mode_q   <= mode_d;
      clk_q    <= clk_d;
      done_q   <= done_d;
    end
  end

  assign clk_RING  = clk_q;
  assign ring_busy = (state_q != ST_IDLE);
  assign ring_done = done_q;

endmodule

// File: tb/tb_contador_clk_multi.sv
// Bench for contador_clk_multi: directed steps from the test plan followed by a
// randomized stretch, all checked every cycle against a cycle-level reference
// model expressed as "cycles left in the phase" and "pulses left in the burst".
module tb_contador_clk_multi;

  localparam int PIX_DIV   = 4;
  localparam int RING_W    = 27;
  localparam int RING_HALF = 3;
  localparam int BURST_W   = 4;

  // ---------------- clock / reset ----------------
  logic               CLK_NX = 1'b0;
  logic               reset;
  logic               en_pix;
  logic               ring_start;
  logic               ring_stop;
  logic               ring_mode;
  logic [BURST_W-1:0] burst_len;
  logic               half_period_ld;
  logic [RING_W-1:0]  half_period;
  logic               pixel_rate;
  logic [1:0]         pix_phase;
  logic               clk_RING;
  logic               ring_busy;
  logic               ring_done;

  always #5 CLK_NX = ~CLK_NX;

  contador_clk_multi #(
    .PIX_DIV  (PIX_DIV),
    .RING_W   (RING_W),
    .RING_HALF(RING_HALF),
    .BURST_W  (BURST_W)
  ) dut (
    .CLK_NX        (CLK_NX),
    .reset         (reset),
    .en_pix        (en_pix),
    .ring_start    (ring_start),
    .ring_stop     (ring_stop),
    .ring_mode     (ring_mode),
    .burst_len     (burst_len),
    .half_period_ld(half_period_ld),
    .half_period   (half_period),
    .pixel_rate    (pixel_rate),
    .pix_phase     (pix_phase),
    .clk_RING      (clk_RING),
    .ring_busy     (ring_busy),
    .ring_done     (ring_done)
  );

  // ---------------- scoreboard counters ----------------
  int checks   = 0;
  int failures = 0;

  // ---------------- reference model ----------------
  int          m_run;      // consecutive enabled edges since en_pix rose
  bit          m_rate;
  bit          m_busy;
  bit          m_high;
  bit          m_mode;
  bit          m_done;
  int          m_left;     // cycles left in the current phase
  int          m_pulses;   // high pulses left in a burst
  int unsigned m_shadow;

  task automatic model_reset();
    m_run    = 0;
    m_rate   = 0;
    m_busy   = 0;
    m_high   = 0;
    m_mode   = 0;
    m_done   = 0;
    m_left   = 0;
    m_pulses = 0;
    m_shadow = RING_HALF;
  endtask

  task automatic model_edge();
    int unsigned new_sh;
    if (!reset) begin
      model_reset();
    end else begin
      if (en_pix) begin
        m_run++;
        m_rate = ((m_run % PIX_DIV) == 0);
      end else begin
        m_run  = 0;
        m_rate = 0;
      end
      new_sh = m_shadow;
      if (half_period_ld) new_sh = (half_period == 0) ? 1 : int'(half_period);
      m_done = 0;
      if (!m_busy) begin
        if (ring_start && !ring_stop) begin
          m_busy   = 1;
          m_high   = 1;
          m_left   = m_shadow;
          m_mode   = ring_mode;
          m_pulses = (burst_len == 0) ? 1 : int'(burst_len);
        end
      end else if (ring_stop) begin
        m_busy = 0;
        m_high = 0;
      end else begin
        m_left--;
        if (m_left == 0) begin
          if (m_high) begin
            m_high = 0;
            m_left = m_shadow;
          end else if (!m_mode || m_pulses > 1) begin
            if (m_mode) m_pulses--;
            m_high = 1;
            m_left = m_shadow;
          end else begin
            m_busy = 0;
            m_done = 1;
          end
        end
      end
      m_shadow = new_sh;
    end
  endtask

  // ---------------- checking ----------------
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  task automatic check_all();
    chk("pixel_rate", 32'(pixel_rate), 32'(m_rate));
    chk("pix_phase",  32'(pix_phase),  32'(m_run % PIX_DIV));
    chk("clk_RING",   32'(clk_RING),   32'(m_busy && m_high));
    chk("ring_busy",  32'(ring_busy),  32'(m_busy));
    chk("ring_done",  32'(ring_done),  32'(m_done));
  endtask

  // ---------------- driver ----------------
  // One clock: model follows the edge, outputs are sampled 1 time unit later,
  // and the caller drives the next inputs after that.
  task automatic step();
    @(posedge CLK_NX);
    model_edge();
    #1;
    check_all();
  endtask

  task automatic async_reset_pulse();
    reset = 1'b0;
    #2;
    model_reset();
    chk("async_clk_RING",  32'(clk_RING),  32'd0);
    chk("async_ring_busy", 32'(ring_busy), 32'd0);
    chk("async_ring_done", 32'(ring_done), 32'd0);
    check_all();
    step();
    reset = 1'b1;
  endtask

  // ---------------- stimulus ----------------
  initial begin : main
    logic [11:0] pat;
    logic [11:0] exp_pat;
    logic [5:0]  pat6;
    logic [5:0]  exp_pat6;
    logic        hist [1:21];
    int          done_cnt;
    int          guard;

    reset          = 1'b0;
    en_pix         = 1'b0;
    ring_start     = 1'b0;
    ring_stop      = 1'b0;
    ring_mode      = 1'b0;
    burst_len      = '0;
    half_period_ld = 1'b0;
    half_period    = '0;
    model_reset();

    // Reset held for three cycles: everything quiet.
    for (int i = 0; i < 3; i++) step();

    // Release with en_pix high: strobes on cycles 4, 8, 12.
    reset  = 1'b1;
    en_pix = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      step();
      chk("pix_strobe_cycle", 32'(pixel_rate), 32'((k % 4) == 0));
    end

    // Drop en_pix at pix_phase==2 for five cycles.
    guard = 0;
    while (pix_phase != 2'd2 && guard < 8) begin
      step();
      guard++;
    end
    chk("reach_phase2", 32'(pix_phase), 32'd2);
    en_pix = 1'b0;
    for (int k = 0; k < 5; k++) step();
    en_pix = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      step();
      if (k == 4) chk("strobe_after_en", 32'(pixel_rate), 32'd1);
    end

    // Burst of two pulses with H=3.
    ring_mode  = 1'b1;
    burst_len  = 4'd2;
    ring_start = 1'b1;
    step();
    ring_start = 1'b0;
    pat      = {11'd0, clk_RING};
    done_cnt = int'(ring_done);
    for (int k = 2; k <= 12; k++) begin
      step();
      pat      = {pat[10:0], clk_RING};
      done_cnt += int'(ring_done);
    end
    exp_pat = 12'b111000111000;
    chk("burst_pattern", 32'(pat), 32'(exp_pat));
    step();
    chk("burst_done_edge", 32'(ring_done), 32'd1);
    chk("burst_busy_fall", 32'(ring_busy), 32'd0);
    done_cnt += int'(ring_done);
    for (int k = 0; k < 4; k++) begin
      step();
      done_cnt += int'(ring_done);
    end
    chk("burst_done_count", 32'(done_cnt), 32'd1);

    // Continuous with a half-period load during the second HIGH phase.
    ring_mode  = 1'b0;
    ring_start = 1'b1;
    step();
    ring_start = 1'b0;
    hist[1] = clk_RING;
    for (int s = 2; s <= 21; s++) begin
      half_period_ld = (s == 8);
      half_period    = 27'd5;
      step();
      hist[s] = clk_RING;
    end
    half_period_ld = 1'b0;
    chk("cont_high2_last", 32'(hist[9]),  32'd1);
    chk("cont_low5_first", 32'(hist[10]), 32'd0);
    chk("cont_low5_last",  32'(hist[14]), 32'd0);
    chk("cont_high5_first",32'(hist[15]), 32'd1);
    chk("cont_high5_last", 32'(hist[19]), 32'd1);
    chk("cont_low_again",  32'(hist[20]), 32'd0);

    // Stop, restore H=3, then stop in the second HIGH cycle.
    ring_stop = 1'b1;
    step();
    ring_stop      = 1'b0;
    half_period_ld = 1'b1;
    half_period    = 27'd3;
    step();
    half_period_ld = 1'b0;
    ring_start     = 1'b1;
    step();
    ring_start = 1'b0;
    step();
    ring_stop = 1'b1;
    step();
    ring_stop = 1'b0;
    chk("stop_clk",  32'(clk_RING),  32'd0);
    chk("stop_busy", 32'(ring_busy), 32'd0);
    chk("stop_done", 32'(ring_done), 32'd0);

    // Start and stop together while idle: stays idle.
    ring_start = 1'b1;
    ring_stop  = 1'b1;
    step();
    ring_start = 1'b0;
    ring_stop  = 1'b0;
    chk("start_stop_idle", 32'(ring_busy), 32'd0);
    step();

    // Burst with H=2, reset pulsed during its LOW phase.
    half_period_ld = 1'b1;
    half_period    = 27'd2;
    step();
    half_period_ld = 1'b0;
    ring_mode  = 1'b1;
    burst_len  = 4'd3;
    ring_start = 1'b1;
    step();
    ring_start = 1'b0;
    step();
    step();
    chk("pre_reset_low", 32'(clk_RING), 32'd0);
    chk("pre_reset_busy", 32'(ring_busy), 32'd1);
    async_reset_pulse();

    // After reset the shadow is back to 3.
    ring_mode  = 1'b0;
    ring_start = 1'b1;
    step();
    ring_start = 1'b0;
    pat6 = {5'd0, clk_RING};
    for (int k = 2; k <= 6; k++) begin
      step();
      pat6 = {pat6[4:0], clk_RING};
    end
    exp_pat6 = 6'b111000;
    chk("post_reset_pattern", 32'(pat6), 32'(exp_pat6));
    ring_stop = 1'b1;
    step();
    ring_stop = 1'b0;

    // Randomized stretch.
    for (int k = 0; k < 400; k++) begin
      en_pix         = ($urandom_range(0, 9) != 0);
      ring_start     = ($urandom_range(0, 7) == 0);
      ring_stop      = ($urandom_range(0, 29) == 0);
      ring_mode      = 1'($urandom_range(0, 1));
      burst_len      = 4'($urandom_range(0, 3));
      half_period_ld = ($urandom_range(0, 9) == 0);
      half_period    = 27'($urandom_range(0, 5));
      step();
    end
    ring_start     = 1'b0;
    ring_stop      = 1'b0;
    half_period_ld = 1'b0;

    // One more asynchronous reset from a random point, then a clean cycle.
    async_reset_pulse();
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/contador_clk_multi.md
Name: contador_clk_multi

Overview:
- Parametrised successor to the fixed clock counter. Derives timing strobes from the single system clock CLK_NX.
- pixel_rate: a one-cycle pixel-rate enable strobe, gated and divided by PIX_DIV.
- clk_RING: a programmable ring/alarm square wave with continuous and burst modes, start/stop control and runtime half-period reload.
- Sits between the clock input and the video timing / alarm logic. Everything downstream uses the strobes as clock enables; no derived clocks.

Parameters:
- PIX_DIV, 4, pixel strobe divider (>=1).
- RING_W, 27, width of ring half-period counter and half_period port.
- RING_HALF, 50000000, reset value of half-period (in CLK_NX cycles).
- BURST_W, 4, width of burst_len.

Ports:
- CLK_NX  in  1  system clock, all logic on rising edge.
- reset  in  1  asynchronous, active-low reset (0 = reset asserted).
- en_pix  in  1  pixel strobe enable.
- ring_start  in  1  start ring, sampled in IDLE only.
- ring_stop  in  1  abort ring.
- ring_mode  in  1  0 = continuous, 1 = burst; sampled with ring_start.
- burst_len  in  BURST_W  number of high pulses in burst; sampled with ring_start.
- half_period_ld  in  1  load strobe for half_period.
- half_period  in  RING_W  new half-period in cycles.
- pixel_rate  out  1  one-cycle strobe every PIX_DIV enabled cycles.
- pix_phase  out  max(1,clog2(PIX_DIV))  current pixel divider count.
- clk_RING  out  1  ring square wave (registered).
- ring_busy  out  1  high while ring FSM not IDLE.
- ring_done  out  1  one-cycle pulse at natural end of a burst.

Behaviour:
- Reset (reset=0, async): pixel_rate=0, pix_phase=0, clk_RING=0, ring_busy=0, ring_done=0, FSM=IDLE, shadow half-period=RING_HALF, burst counter=0.
- Pixel divider:
  - en_pix=1: pix_phase counts 0..PIX_DIV-1 and wraps.
  - pixel_rate=1 (registered) in the cycle where pix_phase==PIX_DIV-1.
  - en_pix=0: pix_phase is held at 0 and pixel_rate=0. First strobe comes PIX_DIV cycles after en_pix returns high.
  - PIX_DIV=1: pixel_rate follows en_pix delayed one cycle; pix_phase stays 0.
- Shadow half-period:
  - half_period_ld=1 writes half_period into the shadow register at the next edge.
  - A value of 0 is stored as 1.
  - The ring counter loads the shadow only at start or at each half-period boundary. It never truncates the current phase.
- Ring FSM states: IDLE, HIGH, LOW.
  - IDLE: ring_start=1 latches mode and burst count (burst_len 0 treated as 1), loads the counter with the shadow, goes to HIGH. clk_RING=1 and ring_busy=1 from the next edge.
  - HIGH: counter decrements each cycle. When counter==1, go to LOW (clk_RING=0) and reload the counter. HIGH lasts exactly H cycles.
  - LOW: lasts H cycles.
    - Continuous mode at end of LOW: go to HIGH.
    - Burst mode with remaining>1: decrement remaining, go to HIGH.
    - Burst mode with remaining==1: go to IDLE, ring_busy=0, ring_done=1 for one cycle on the same edge.
  - ring_stop=1 in any non-IDLE state: IDLE at next edge, clk_RING=0, ring_busy=0, no ring_done.
  - ring_stop and ring_start together in IDLE: stop wins, stay IDLE.
  - ring_start while busy: ignored. mode/burst_len changes while busy: ignored.
- half_period_ld in the same cycle as a boundary: the old shadow value is used for the next phase; the new value applies from the following boundary.
- Mid-operation reset: all outputs return to reset values immediately (async). Operation restarts cleanly after reset=1 with the first rising edge.
- Counter arithmetic is unsigned RING_W bits. A maximum half_period of 2^RING_W-1 is supported without wrap.

Test Plan (PIX_DIV=4, RING_HALF=3, BURST_W=4):
- Reset held low 3 cycles, then released with en_pix=1 -> all outputs 0 during reset; pixel_rate pulses on cycles 4, 8, 12 after release; pix_phase sequence 0,1,2,3,0.
- en_pix dropped for 5 cycles mid-count (at pix_phase=2) -> pix_phase=0, no strobe while low; next strobe 4 cycles after en_pix=1.
- ring_start, mode=1, burst_len=2 -> clk_RING pattern 1,1,1,0,0,0,1,1,1,0,0,0; ring_done pulses once as ring_busy falls; no further pulses.
- Continuous start; half_period_ld with 5 during the second HIGH phase -> that HIGH lasts 3 cycles; the next LOW and all later phases last 5 cycles.
- ring_stop asserted during the 2nd HIGH cycle of continuous mode -> clk_RING=0 and ring_busy=0 next edge; ring_done stays 0. ring_start and ring_stop together in IDLE -> remains IDLE.
- reset pulsed low mid-burst (LOW phase) -> clk_RING, ring_busy and ring_done=0 asynchronously; shadow back to 3; a new start gives 3-cycle phases.
